// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the unified memory port arbiter used by cpu_top.
//   arb_state_t    : arbiter FSM states (IDLE issues, WAIT counts out latency)
//   arb_owner_t    : which requester owns the single outstanding access
//   MEM_LAT_DEF    : default issue-to-data latency in cycles
//   STARVE_MAX_DEF : default number of data grants fetch may be held off for
package cpu_mem_pkg;

    typedef enum logic {
        IDLE,
        WAIT
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } arb_owner_t;

    localparam int MEM_LAT_DEF    = 2;
    localparam int STARVE_MAX_DEF = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requests.
//   if_req  : fetch request
//   dm_req  : data request
//   starved : starvation counter has saturated
//   pick    : one-hot winner, bit 0 = fetch, bit 1 = data, 0 = no request
module mem_arb_pick (
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       starved,
    output logic [1:0] pick
);

    // Data wins by default; a saturated starvation count hands the port to fetch.
    always_comb begin
        pick = 2'b00;
        if (if_req && (starved || !dm_req)) begin
            pick = 2'b01;
        end else if (dm_req) begin
            pick = 2'b10;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the memory port shared by instruction fetch and data
// access. One access is in flight at a time; the response is returned to the
// owner MEM_LAT cycles after issue. Also produces per-stage stall signals.
//   clk, reset                       : clock, synchronous active-low reset
//   if_req/if_addr                   : fetch request and address
//   if_gnt/if_rvalid/if_rdata        : fetch issue strobe, response, data
//   dm_req/dm_we/dm_addr/dm_wdata    : data request, write enable, addr, wdata
//   dm_gnt/dm_rvalid/dm_rdata        : data issue strobe, response, read data
//   mem_en/mem_we/mem_addr/mem_wdata : memory port drive
//   mem_rdata                        : memory read data, valid MEM_LAT after issue
//   stall_if/stall_mem               : request pending without a response
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int SW    = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    arb_state_t       state_q, state_d;
    arb_owner_t       owner_q, owner_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [SW-1:0]    starv_q, starv_d;
    logic             we_q, we_d;
    logic             armed_q;   // low during reset and the first cycle after release
    logic             active;
    logic             starved;
    logic [1:0]       pick;

    assign active  = reset && armed_q;
    assign starved = (starv_q == SW'(STARVE_MAX));

    mem_arb_pick u_pick (
        .if_req  (if_req),
        .dm_req  (dm_req),
        .starved (starved),
        .pick    (pick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= OWN_NONE;
            lat_q   <= '0;
            starv_q <= '0;
            we_q    <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            lat_q   <= lat_d;
            starv_q <= starv_d;
            we_q    <= we_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_d     = lat_q;
        starv_d   = starv_q;
        we_d      = we_q;
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        dm_gnt    = 1'b0;
        dm_rvalid = 1'b0;
        dm_rdata  = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        if (active) begin
            case (state_q)
                IDLE: begin
                    if (pick != 2'b00) begin
                        mem_en  = 1'b1;
                        lat_d   = LAT_W'(MEM_LAT);
                        state_d = WAIT;
                        if (pick[0]) begin
                            if_gnt   = 1'b1;
                            mem_addr = if_addr;
                            owner_d  = OWN_IF;
                            we_d     = 1'b0;
                        end else begin
                            dm_gnt    = 1'b1;
                            mem_addr  = dm_addr;
                            mem_we    = dm_we;
                            mem_wdata = dm_wdata;
                            owner_d   = OWN_DM;
                            we_d      = dm_we;
                        end
                    end
                end
                WAIT: begin
                    lat_d = lat_q - LAT_W'(1);
                    // Count hits zero this cycle: mem_rdata is valid now.
                    if (lat_q == LAT_W'(1)) begin
                        state_d = IDLE;
                        owner_d = OWN_NONE;
                        if (owner_q == OWN_IF) begin
                            if_rvalid = 1'b1;
                            if_rdata  = mem_rdata;
                        end else if (owner_q == OWN_DM) begin
                            dm_rvalid = 1'b1;
                            if (!we_q) begin
                                dm_rdata = mem_rdata;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (!if_req || if_gnt) begin
                starv_d = '0;
            end else if (dm_gnt && !starved) begin
                starv_d = starv_q + SW'(1);
            end
        end
    end

    assign stall_if  = reset & if_req & ~if_rvalid;
    assign stall_mem = reset & dm_req & ~dm_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int LAT  = 2;
    localparam int SMAX = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_gnt, dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall_if, stall_mem;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Transaction-timeline reference: a grant at cycle T owns the port until
    // the response at T+LAT; nothing new may issue before T+LAT+1.
    int  cyc      = 0;
    int  m_who    = 0;      // 0 none, 1 fetch, 2 data
    int  m_due    = 0;
    bit  m_wr     = 1'b0;
    int  m_starve = 0;
    bit  m_armed  = 1'b0;

    always @(negedge clk) begin : model
        logic          e_ig, e_dg, e_iv, e_dv, e_en, e_we, e_si, e_sm;
        logic [63:0]   e_ird, e_drd, e_addr, e_wd;
        e_ig = 1'b0; e_dg = 1'b0; e_iv = 1'b0; e_dv = 1'b0;
        e_en = 1'b0; e_we = 1'b0;
        e_ird = '0; e_drd = '0; e_addr = '0; e_wd = '0;
        if (reset && m_armed) begin
            if (m_who != 0) begin
                if (cyc == m_due) begin
                    if (m_who == 1) begin
                        e_iv  = 1'b1;
                        e_ird = mem_rdata;
                    end else begin
                        e_dv  = 1'b1;
                        e_drd = m_wr ? 64'd0 : mem_rdata;
                    end
                    m_who = 0;
                end
            end else if (if_req && (m_starve == SMAX || !dm_req)) begin
                e_ig = 1'b1; e_en = 1'b1; e_addr = if_addr;
                m_who = 1; m_due = cyc + LAT;
            end else if (dm_req) begin
                e_dg = 1'b1; e_en = 1'b1; e_we = dm_we;
                e_addr = dm_addr; e_wd = dm_wdata;
                m_who = 2; m_wr = dm_we; m_due = cyc + LAT;
            end
            if (!if_req || e_ig) m_starve = 0;
            else if (e_dg && m_starve < SMAX) m_starve++;
        end
        e_si = reset && if_req && !e_iv;
        e_sm = reset && dm_req && !e_dv;

        chk1("if_gnt", if_gnt, e_ig);
        chk1("dm_gnt", dm_gnt, e_dg);
        chk1("if_rvalid", if_rvalid, e_iv);
        chk1("dm_rvalid", dm_rvalid, e_dv);
        chk("if_rdata", if_rdata, e_ird);
        chk("dm_rdata", dm_rdata, e_drd);
        chk1("mem_en", mem_en, e_en);
        chk1("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk1("stall_if", stall_if, e_si);
        chk1("stall_mem", stall_mem, e_sm);
        chk1("rvalid_both", if_rvalid && dm_rvalid, 1'b0);

        if (!reset) begin
            m_who    = 0;
            m_starve = 0;
        end
        m_armed = reset;
        cyc++;
    end

    bit ih = 1'b0, dh = 1'b0, idone = 1'b0, ddone = 1'b0;
    int rst_left = 0;

    initial begin
        // Reset held low with a fetch request pending: everything silent.
        repeat (3) @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = 64'h8;
        @(negedge clk);
        chk1("rst_if_gnt", if_gnt, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_stall_if", stall_if, 1'b0);
        next_cycle();

        // Release: first cycle is quiet, grant on the second.
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if_req = (c <= 3);
            @(negedge clk);
            chk1("rel_if_gnt", if_gnt, c == 1);
            chk1("rel_if_rvalid", if_rvalid, c == 3);
            if (c == 0) begin
                chk1("rel_mem_en0", mem_en, 1'b0);
                chk1("rel_stall_if0", stall_if, 1'b1);
            end
            next_cycle();
        end

        // Collision: data read 0x40 and fetch 0x10 together.
        dm_we = 1'b0; dm_addr = 64'h40; if_addr = 64'h10;
        for (int c = 0; c < 7; c++) begin
            dm_req    = (c <= 2);
            if_req    = (c <= 5);
            mem_rdata = 64'h1000 + 64'(c);
            @(negedge clk);
            chk1("col_dm_gnt", dm_gnt, c == 0);
            chk1("col_dm_rvalid", dm_rvalid, c == 2);
            chk1("col_if_gnt", if_gnt, c == 3);
            chk1("col_if_rvalid", if_rvalid, c == 5);
            chk1("col_stall_if", stall_if, c <= 4);
            if (c == 0) chk("col_addr0", mem_addr, 64'h40);
            if (c == 2) chk("col_dm_rdata", dm_rdata, 64'h1002);
            if (c == 3) chk("col_addr3", mem_addr, 64'h10);
            if (c == 5) chk("col_if_rdata", if_rdata, 64'h1005);
            next_cycle();
        end

        // Starvation guard with both requests held.
        for (int c = 0; c < 16; c++) begin
            dm_req = (c <= 14);
            if_req = (c <= 12);
            @(negedge clk);
            chk1("stv_dm_gnt", dm_gnt, (c % 3 == 0) && c != 9 && c <= 12);
            chk1("stv_if_gnt", if_gnt, c == 9);
            next_cycle();
        end

        // Write access.
        dm_we = 1'b1; dm_addr = 64'h80; dm_wdata = 64'hDEAD;
        for (int c = 0; c < 4; c++) begin
            dm_req    = (c <= 2);
            mem_rdata = 64'h5555_0000 + 64'(c);
            @(negedge clk);
            if (c == 0) begin
                chk1("wr_mem_en", mem_en, 1'b1);
                chk1("wr_mem_we", mem_we, 1'b1);
                chk("wr_wdata", mem_wdata, 64'hDEAD);
                chk("wr_addr", mem_addr, 64'h80);
            end
            if (c == 1) chk1("wr_mem_en1", mem_en, 1'b0);
            chk1("wr_dm_rvalid", dm_rvalid, c == 2);
            if (c == 2) chk("wr_dm_rdata", dm_rdata, 64'h0);
            next_cycle();
        end
        dm_we = 1'b0;

        // Reset in the middle of a fetch.
        if_addr = 64'h20;
        for (int c = 0; c < 7; c++) begin
            if_req = (c <= 5);
            reset  = (c != 1);
            @(negedge clk);
            chk1("rma_if_gnt", if_gnt, c == 0 || c == 3);
            chk1("rma_if_rvalid", if_rvalid, c == 5);
            if (c == 1 || c == 2) begin
                chk1("rma_mem_en", mem_en, 1'b0);
                chk("rma_mem_addr", mem_addr, 64'h0);
            end
            if (c == 2) chk1("rma_stall_if", stall_if, 1'b1);
            if (c == 3) chk("rma_addr3", mem_addr, 64'h20);
            next_cycle();
        end

        // Fetch request pulsed only while a data read is in flight.
        dm_addr = 64'h100;
        for (int c = 0; c < 6; c++) begin
            dm_req = (c <= 2);
            if_req = (c == 1);
            @(negedge clk);
            chk1("abn_if_gnt", if_gnt, 1'b0);
            chk1("abn_dm_gnt", dm_gnt, c == 0);
            chk1("abn_dm_rvalid", dm_rvalid, c == 2);
            if (c >= 3) begin
                chk1("abn_mem_en", mem_en, 1'b0);
                chk1("abn_stall_if", stall_if, 1'b0);
                chk1("abn_stall_mem", stall_mem, 1'b0);
            end
            next_cycle();
        end

        // Randomized traffic honouring the hold rule, with occasional resets.
        for (int k = 0; k < 4000; k++) begin
            if (rst_left > 0) begin
                reset = 1'b0;
                rst_left--;
            end else begin
                reset = 1'b1;
                if ($urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
            end
            mem_rdata = rnd64();
            if (!ih) begin
                if (idone) begin
                    if ($urandom_range(0, 1) == 1) begin
                        if_req = 1'b1; if_addr = rnd64();
                    end else begin
                        if_req = 1'b0;
                    end
                end else if (if_req) begin
                    if ($urandom_range(0, 7) == 0) if_req = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    if_req = 1'b1; if_addr = rnd64();
                end
            end
            if (!dh) begin
                if (ddone || (!dm_req && $urandom_range(0, 2) == 0)) begin
                    dm_req = (ddone ? ($urandom_range(0, 1) == 1) : 1'b1);
                    dm_we = ($urandom_range(0, 1) == 1);
                    dm_addr = rnd64();
                    dm_wdata = rnd64();
                end else if (dm_req && $urandom_range(0, 7) == 0) begin
                    dm_req = 1'b0;
                end
            end
            idone = 1'b0;
            ddone = 1'b0;
            @(negedge clk);
            if (!reset) begin
                ih = 1'b0;
                dh = 1'b0;
            end else begin
                if (if_gnt) ih = 1'b1;
                if (if_rvalid) begin ih = 1'b0; idone = 1'b1; end
                if (dm_gnt) dh = 1'b1;
                if (dm_rvalid) begin dh = 1'b0; ddone = 1'b1; end
            end
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
